// File: rtl/cc1200_spi_responder_if.sv
// CC1200 SPI bus: master drives clock/data/select, responder drives MISO and its enable.
interface cc1200_spi_responder_if;
  logic SCLK;
  logic MOSI;
  logic CS_n;
  logic MISO;
  logic MISO_oe;

  modport master (output SCLK, output MOSI, output CS_n, input MISO, input MISO_oe);
  modport slave  (input SCLK, input MOSI, input CS_n, output MISO, output MISO_oe);
endinterface

// File: rtl/cc1200_spi_responder.sv
// CC1200 register/strobe model on the SPI responder side, oversampling SCLK/MOSI/CS_n in clk.
module cc1200_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  cc1200_spi_responder_if.slave    spi,
  output logic                     wr_valid,
  output logic [5:0]               wr_addr,
  output logic [7:0]               wr_data,
  output logic                     strobe,
  output logic [5:0]               strobe_addr,
  input  logic [5:0]               host_addr,
  output logic [7:0]               host_rdata
);

  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_e;

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
  logic             sclk_prev_q, csn_prev_q;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       rx_q, rx_d;
  logic [DW-1:0]    tx_q, tx_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             rw_q, rw_d, burst_q, burst_d;
  logic [2:0]       chip_state_q, chip_state_d;
  logic             miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic             wr_valid_q, wr_valid_d, strobe_q, strobe_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d, strobe_addr_q, strobe_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d, host_rdata_q;
  logic [DW-1:0]    regs_q [NREG];
  logic             reg_we, sres;

  logic             sclk_s, mosi_s, csn_s;
  logic             sclk_rise, sclk_fall, cs_fall, cs_rise, byte_done, is_strobe;
  logic [DW-1:0]    rx_byte, stat_cur;
  logic [AW-1:0]    hdr_addr, ptr_inc;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  // SCLK edges only count while CS_n was low in the previous sample, so a
  // final rise coinciding with the CS_n rise still completes its byte.
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~csn_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~csn_prev_q;
  assign cs_fall   = ~csn_s & csn_prev_q;
  assign cs_rise   = csn_s & ~csn_prev_q;
  assign rx_byte   = {rx_q, mosi_s};
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
  assign hdr_addr  = rx_byte[5:0];
  assign is_strobe = (hdr_addr >= 6'h30) && (hdr_addr <= 6'h3D);
  assign ptr_inc   = AW'(ptr_q + 6'd1);
  assign stat_cur  = {1'b0, chip_state_q, 4'b0000};

  // Input synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi.CS_n};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: header/data byte sequencing, CS_n rise always returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_HDR;
      ST_HDR:  if (byte_done && !is_strobe) state_d = ST_DATA;
      ST_DATA: if (byte_done && !burst_q) state_d = ST_HDR;
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && cs_rise) state_d = ST_IDLE;
  end

  // Datapath/output next values: shifting, decode, strobes, writes and MISO.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    ptr_d         = ptr_q;
    rw_d          = rw_q;
    burst_d       = burst_q;
    chip_state_d  = chip_state_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    wr_valid_d    = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    strobe_d      = 1'b0;
    strobe_addr_d = strobe_addr_q;
    reg_we        = 1'b0;
    sres          = 1'b0;
    if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        miso_oe_d = 1'b1;
        miso_d    = stat_cur[7];
        tx_d      = stat_cur;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = 3'(bit_cnt_q + 3'd1);
      end
      if (byte_done) begin
        if (state_q == ST_HDR) begin
          if (is_strobe) begin
            strobe_d      = 1'b1;
            strobe_addr_d = hdr_addr;
            case (hdr_addr)
              6'h30: begin sres = 1'b1; chip_state_d = 3'd0; end
              6'h34: chip_state_d = 3'd1;
              6'h35: chip_state_d = 3'd2;
              6'h36: chip_state_d = 3'd0;
              default: ;
            endcase
            // Next header reports the state as left by this strobe.
            tx_d = {1'b0, chip_state_d, 4'b0000};
          end else begin
            ptr_d   = hdr_addr;
            rw_d    = rx_byte[7];
            burst_d = rx_byte[6];
            tx_d    = rx_byte[7] ? regs_q[hdr_addr] : stat_cur;
          end
        end else begin
          if (!rw_q) begin
            reg_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = rx_byte;
          end
          if (burst_q) begin
            ptr_d = ptr_inc;
            tx_d  = rw_q ? regs_q[ptr_inc] : stat_cur;
          end else begin
            tx_d = stat_cur;
          end
        end
      end
      // bit_cnt is 0 at a byte boundary, so the fall drives bit 7 of the new byte.
      if (sclk_fall) miso_d = tx_q[3'd7 - bit_cnt_q];
      if (cs_rise) begin
        miso_oe_d = 1'b0;
        miso_d    = 1'b0;
        bit_cnt_d = 3'd0;
        ptr_d     = '0;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      ptr_q         <= '0;
      rw_q          <= 1'b0;
      burst_q       <= 1'b0;
      chip_state_q  <= 3'd0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      strobe_q      <= 1'b0;
      strobe_addr_q <= '0;
      host_rdata_q  <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      ptr_q         <= ptr_d;
      rw_q          <= rw_d;
      burst_q       <= burst_d;
      chip_state_q  <= chip_state_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      strobe_q      <= strobe_d;
      strobe_addr_q <= strobe_addr_d;
      host_rdata_q  <= regs_q[host_addr];
    end
  end

  // 64x8 register file, cleared by reset or the SRES strobe.
  always_ff @(posedge clk) begin
    if (rst || sres) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
    end else if (reg_we) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  assign spi.MISO    = miso_q;
  assign spi.MISO_oe = miso_oe_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign strobe      = strobe_q;
  assign strobe_addr = strobe_addr_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_cc1200_spi_responder.sv
// Bench: SPI master driving the responder, with a CC1200 model feeding write/strobe/MISO scoreboards.
module tb_cc1200_spi_responder;

  localparam int unsigned H = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, strobe;
  logic [5:0] wr_addr, strobe_addr, host_addr;
  logic [7:0] wr_data, host_rdata;

  always #5 clk = ~clk;

  cc1200_spi_responder_if spi ();

  cc1200_spi_responder #(.SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .strobe      (strobe),
    .strobe_addr (strobe_addr),
    .host_addr   (host_addr),
    .host_rdata  (host_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0]  mdl_regs [64];
  logic [2:0]  mdl_state;
  logic        mdl_hdr, mdl_rw, mdl_burst;
  logic [5:0]  mdl_ptr;
  logic [7:0]  mdl_tx;
  logic [13:0] wr_q [$];
  logic [5:0]  stb_q [$];
  logic [7:0]  miso_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdl_stat();
    return {1'b0, mdl_state, 4'b0000};
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 64; i++) mdl_regs[i] = 8'h00;
    mdl_state = 3'd0;
  endtask

  // Model one complete byte: push the MISO byte the master should see plus any write/strobe.
  task automatic mdl_byte(input logic [7:0] b);
    logic [5:0] a;
    miso_q.push_back(mdl_tx);
    if (mdl_hdr) begin
      a = b[5:0];
      if (a >= 6'h30 && a <= 6'h3D) begin
        stb_q.push_back(a);
        if (a == 6'h30) mdl_reset();
        else if (a == 6'h34) mdl_state = 3'd1;
        else if (a == 6'h35) mdl_state = 3'd2;
        else if (a == 6'h36) mdl_state = 3'd0;
        mdl_tx = mdl_stat();
      end else begin
        mdl_ptr   = a;
        mdl_rw    = b[7];
        mdl_burst = b[6];
        mdl_hdr   = 1'b0;
        mdl_tx    = mdl_rw ? mdl_regs[mdl_ptr] : mdl_stat();
      end
    end else begin
      if (!mdl_rw) begin
        mdl_regs[mdl_ptr] = b;
        wr_q.push_back({mdl_ptr, b});
      end
      if (mdl_burst) begin
        mdl_ptr = mdl_ptr + 6'd1;
        mdl_tx  = mdl_rw ? mdl_regs[mdl_ptr] : mdl_stat();
      end else begin
        mdl_hdr = 1'b1;
        mdl_tx  = mdl_stat();
      end
    end
  endtask

  // Write and strobe pulses are popped against the scoreboard as they appear.
  always @(negedge clk) begin
    logic [13:0] we;
    logic [5:0]  se;
    if (wr_valid) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'(wr_valid), 32'd0);
      else begin
        we = wr_q.pop_front();
        check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(we));
      end
    end
    if (strobe) begin
      if (stb_q.size() == 0) check("strobe_unexpected", 32'(strobe), 32'd0);
      else begin
        se = stb_q.pop_front();
        check("strobe_addr", 32'(strobe_addr), 32'(se));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi.CS_n = 1'b0;
    mdl_hdr  = 1'b1;
    mdl_tx   = mdl_stat();
    tick(H);
    check("miso_oe_on", 32'(spi.MISO_oe), 32'd1);
  endtask

  task automatic cs_high();
    tick(H);
    spi.CS_n = 1'b1;
    tick(6);
    check("miso_oe_off", 32'(spi.MISO_oe), 32'd0);
    check("miso_off", 32'(spi.MISO), 32'd0);
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi.MOSI = tx[7-i];
      tick(H);
      rx[7-i]  = spi.MISO;
      spi.SCLK = 1'b1;
      tick(H);
      spi.SCLK = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx, e;
    mdl_byte(b);
    spi_bits(b, 8, rx);
    e = miso_q.pop_front();
    check($sformatf("miso_byte_%02h", b), 32'(rx), 32'(e));
  endtask

  task automatic host_chk(input logic [5:0] a);
    host_addr = a;
    tick(2);
    check($sformatf("host_rdata_%02h", a), 32'(host_rdata), 32'(mdl_regs[a]));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    check({pfx, "_miso"}, 32'(spi.MISO), 32'd0);
    check({pfx, "_miso_oe"}, 32'(spi.MISO_oe), 32'd0);
    check({pfx, "_wr_valid"}, 32'(wr_valid), 32'd0);
    check({pfx, "_strobe"}, 32'(strobe), 32'd0);
    check({pfx, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({pfx, "_wr_data"}, 32'(wr_data), 32'd0);
    check({pfx, "_strobe_addr"}, 32'(strobe_addr), 32'd0);
    check({pfx, "_host_rdata"}, 32'(host_rdata), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    spi.CS_n = 1'b1;
    host_addr = 6'h00;
    rst = 1'b1;
    mdl_reset();
    mdl_hdr = 1'b1; mdl_rw = 1'b0; mdl_burst = 1'b0; mdl_ptr = 6'h00; mdl_tx = 8'h00;
    tick(3);
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick(4);

    // Single write then read-back.
    cs_low(); send(8'h05); send(8'hA5); cs_high();
    host_chk(6'h05);
    cs_low(); send(8'h85); send(8'h00); cs_high();

    // Burst write wrapping 0x3F -> 0x00.
    cs_low(); send(8'h7E); send(8'h11); send(8'h22); send(8'h33); cs_high();
    host_chk(6'h3E); host_chk(6'h3F); host_chk(6'h00);

    // SRX strobe, then a header in the same transfer reports status 0x10.
    cs_low(); send(8'h34); send(8'h80); send(8'h00); cs_high();

    // SRES clears regs and state.
    cs_low(); send(8'h30); cs_high();
    cs_low(); send(8'h85); send(8'h00); cs_high();
    host_chk(6'h3E);

    // STX, write under status 0x20, a pulse-only strobe, then SIDLE.
    cs_low(); send(8'h35); send(8'h07); send(8'h5A); send(8'h3D); send(8'h36); cs_high();
    host_chk(6'h07);

    // Abort a partial data byte.
    cs_low(); send(8'h06); send(8'h77); cs_high();
    cs_low(); send(8'h06); spi_bits(8'hF0, 5, rx); cs_high();
    host_chk(6'h06);
    check("abort_no_pending_wr", 32'(wr_q.size()), 32'd0);
    cs_low(); send(8'h86); send(8'h00); cs_high();

    // Reset in the middle of a burst read.
    cs_low(); send(8'h34); cs_high();
    cs_low(); send(8'hC0); send(8'h00); spi_bits(8'h00, 3, rx);
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("midrst");
    spi.CS_n = 1'b1;
    spi.SCLK = 1'b0;
    mdl_reset();
    tick(4);
    rst = 1'b0;
    tick(4);
    host_chk(6'h3E);
    cs_low(); send(8'h87); send(8'h00); cs_high();

    tick(10);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("strobe_queue_drained", 32'(stb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
